// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - WS2812 state encoding, 40 MHz timing defaults and GRB field positions
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SEND,
        LATCH
    } state_t;

    localparam int DEF_N_LEDS     = 120;
    localparam int DEF_RD_LATENCY = 1;
    localparam int DEF_T0H        = 16;
    localparam int DEF_T1H        = 32;
    localparam int DEF_T_BIT      = 50;
    localparam int DEF_T_RESET    = 2400;

    localparam int GRB_BITS = 24;
    localparam int BR_MSB   = 31;
    localparam int BR_LSB   = 24;
    localparam int G_MSB    = 23;
    localparam int G_LSB    = 16;
    localparam int R_MSB    = 15;
    localparam int R_LSB    = 8;
    localparam int B_MSB    = 7;
    localparam int B_LSB    = 0;

    // (c * (br + 1)) >> 8: br = 255 passes the channel through unchanged
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, br} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - WS2812 bit waveform generator and latch timer
module ws2812_bit_encoder #(
    parameter int T0H     = 16,
    parameter int T1H     = 32,
    parameter int T_BIT   = 50,
    parameter int T_RESET = 2400
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_launch,
    input  logic i_bit,
    input  logic i_latch,
    output logic o_line,
    output logic o_done
);
    localparam int T_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] BIT_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(T_RESET - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] high_len;
    logic          active;
    logic          latch_mode;
    logic          bit_r;

    assign cnt_inc  = cnt + CW'(1);
    assign high_len = bit_r ? T1H_C : T0H_C;
    assign o_done   = active && (cnt == (latch_mode ? RST_LAST : BIT_LAST));

    // Launch starts a new period on the next cycle; the done cycle may relaunch for a gapless stream
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= '0;
            active     <= 1'b0;
            latch_mode <= 1'b0;
            bit_r      <= 1'b0;
            o_line     <= 1'b0;
        end else if (i_launch) begin
            cnt        <= '0;
            active     <= 1'b1;
            latch_mode <= 1'b0;
            bit_r      <= i_bit;
            o_line     <= 1'b1;
        end else if (i_latch) begin
            cnt        <= '0;
            active     <= 1'b1;
            latch_mode <= 1'b1;
            o_line     <= 1'b0;
        end else if (active) begin
            if (o_done) begin
                cnt    <= '0;
                active <= 1'b0;
                o_line <= 1'b0;
            end else begin
                cnt    <= cnt_inc;
                o_line <= !latch_mode && (cnt_inc < high_len);
            end
        end
    end

endmodule

// File: rtl/led_ram_ws2812_tx.sv
// rtl/led_ram_ws2812_tx.sv - led_ram frame reader and WS2812 serialiser (option macro: LED_BRIGHTNESS_EN)
module led_ram_ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int N_LEDS     = DEF_N_LEDS,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int T_BIT      = DEF_T_BIT,
    parameter int T_RESET    = DEF_T_RESET
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [10:0] o_led_ram_address,
    output logic        o_led_ram_chipselect,
    output logic        o_led_ram_clken,
    output logic        o_led_ram_write,
    output logic [31:0] o_led_ram_writedata,
    output logic [3:0]  o_led_ram_byteenable,
    input  logic [31:0] i_led_ram_readdata,
    output logic        o_led_dout
);
    localparam logic [10:0] LAST_IDX = 11'(N_LEDS - 1);
    localparam logic [4:0]  LAST_BIT = 5'(GRB_BITS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic                  rd_valid;
    logic                  word_valid;
    logic [23:0]           word_data;
    logic [23:0]           shift_q;
    logic [23:0]           shift_nxt;
    logic [23:0]           pf_q;
    logic [4:0]            bit_cnt;
    logic [10:0]           led_idx;
    logic                  start_ok;
    logic                  first_load;
    logic                  bit_done;
    logic                  shift_bit;
    logic                  led_load;
    logic                  enc_launch;
    logic                  enc_latch;
    logic                  enc_bit;
    logic                  enc_done;

    assign o_led_ram_clken      = 1'b1;
    assign o_led_ram_write      = 1'b0;
    assign o_led_ram_writedata  = 32'd0;
    assign o_led_ram_byteenable = 4'hF;

    assign rd_valid = rd_pipe[RD_LATENCY-1];

    // Delay each read strobe by the RAM latency to mark the cycle its data is on readdata
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= o_led_ram_chipselect;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

`ifdef LED_BRIGHTNESS_EN
    logic        sc_valid;
    logic [23:0] sc_data;

    // Scale all three channels by the word's brightness byte, one cycle after the read returns
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sc_valid <= 1'b0;
            sc_data  <= '0;
        end else begin
            sc_valid <= rd_valid;
            sc_data  <= {scale_channel(i_led_ram_readdata[G_MSB:G_LSB], i_led_ram_readdata[BR_MSB:BR_LSB]),
                         scale_channel(i_led_ram_readdata[R_MSB:R_LSB], i_led_ram_readdata[BR_MSB:BR_LSB]),
                         scale_channel(i_led_ram_readdata[B_MSB:B_LSB], i_led_ram_readdata[BR_MSB:BR_LSB])};
        end
    end

    assign word_valid = sc_valid;
    assign word_data  = sc_data;
`else
    logic unused_brightness;

    assign unused_brightness = ^i_led_ram_readdata[BR_MSB:BR_LSB];
    assign word_valid        = rd_valid;
    assign word_data         = i_led_ram_readdata[G_MSB:B_LSB];
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a frame walks IDLE -> PRIME -> SEND -> LATCH and back
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_ok)   state_nxt = PRIME;
            PRIME: if (first_load) state_nxt = SEND;
            SEND:  if (enc_latch)  state_nxt = LATCH;
            LATCH: if (enc_done)   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // FSM outputs: encoder strobes and the next shift-register contents
    always_comb begin
        o_busy     = (state != IDLE);
        start_ok   = (state == IDLE) && i_start && !o_frame_done;
        first_load = (state == PRIME) && word_valid;
        bit_done   = (state == SEND) && enc_done;
        shift_bit  = bit_done && (bit_cnt != LAST_BIT);
        led_load   = bit_done && (bit_cnt == LAST_BIT) && (led_idx != LAST_IDX);
        enc_latch  = bit_done && (bit_cnt == LAST_BIT) && (led_idx == LAST_IDX);
        enc_launch = first_load || shift_bit || led_load;
        shift_nxt  = shift_q << 1;
        if (first_load) begin
            shift_nxt = word_data;
        end else if (led_load) begin
            shift_nxt = pf_q;
        end
        enc_bit = shift_nxt[23];
    end

    // Read issue, prefetch buffer, shift register and bit/LED counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_led_ram_address    <= '0;
            o_led_ram_chipselect <= 1'b0;
            o_frame_done         <= 1'b0;
            shift_q              <= '0;
            pf_q                 <= '0;
            bit_cnt              <= '0;
            led_idx              <= '0;
        end else begin
            o_led_ram_chipselect <= 1'b0;
            o_frame_done         <= (state == LATCH) && enc_done;
            if (start_ok) begin
                o_led_ram_address    <= '0;
                o_led_ram_chipselect <= 1'b1;
            end
            if (enc_launch) begin
                shift_q <= shift_nxt;
            end
            if (first_load) begin
                bit_cnt <= '0;
                led_idx <= '0;
                if (N_LEDS > 1) begin
                    o_led_ram_address    <= 11'd1;
                    o_led_ram_chipselect <= 1'b1;
                end
            end
            if (shift_bit) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (led_load) begin
                bit_cnt <= '0;
                led_idx <= led_idx + 11'd1;
                if (o_led_ram_address != LAST_IDX) begin
                    o_led_ram_address    <= o_led_ram_address + 11'd1;
                    o_led_ram_chipselect <= 1'b1;
                end
            end
            if ((state == SEND) && word_valid) begin
                pf_q <= word_data;
            end
        end
    end

    ws2812_bit_encoder #(
        .T0H     (T0H),
        .T1H     (T1H),
        .T_BIT   (T_BIT),
        .T_RESET (T_RESET)
    ) u_enc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_launch (enc_launch),
        .i_bit    (enc_bit),
        .i_latch  (enc_latch),
        .o_line   (o_led_dout),
        .o_done   (enc_done)
    );

endmodule

// File: tb/tb_led_ram_ws2812_tx.sv
// tb/tb_led_ram_ws2812_tx.sv - scoreboard bench for led_ram_ws2812_tx with a three-LED strip
module tb_led_ram_ws2812_tx;

    localparam int N       = 3;
    localparam int TH0     = 16;
    localparam int TH1     = 32;
    localparam int TBIT    = 50;
    localparam int TRST    = 2400;
    localparam int FRAME   = N * 24 * TBIT + TRST;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [10:0] addr;
    logic        cs;
    logic        clken;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata = 32'd0;
    logic        dout;

    logic [31:0] mem [0:N-1];
    bit          exp_q[$];
    int          addr_q[$];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    bit  mon_abort;
    bit  prev_dout = 1'b0;
    bit  in_bit = 1'b0;
    bit  frame_active = 1'b0;
    int  hi_cnt = 0;
    int  last_rise = 0;
    int  first_rise = 0;
    int  f1, f2, f3;

    led_ram_ws2812_tx #(.N_LEDS(N)) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_start              (start),
        .o_busy               (busy),
        .o_frame_done         (frame_done),
        .o_led_ram_address    (addr),
        .o_led_ram_chipselect (cs),
        .o_led_ram_clken      (clken),
        .o_led_ram_write      (wr),
        .o_led_ram_writedata  (wdata),
        .o_led_ram_byteenable (be),
        .i_led_ram_readdata   (rdata),
        .o_led_dout           (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cs && addr < 11'(N)) rdata <= mem[addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Decode the line: each high pulse pops one expected bit, rises must be T_BIT apart
    always @(negedge clk) begin
        if (mon_abort) begin
            in_bit       = 1'b0;
            frame_active = 1'b0;
            hi_cnt       = 0;
            if (frame_done) done_cnt++;
        end else begin
            if (dout && !prev_dout) begin
                if (in_bit) check("bit_period", cyc - last_rise, TBIT);
                if (!frame_active) begin
                    frame_active = 1'b1;
                    first_rise   = cyc;
                end
                last_rise = cyc;
                in_bit    = 1'b1;
                hi_cnt    = 1;
            end else if (dout) begin
                hi_cnt++;
            end else if (prev_dout) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    bit eb;
                    eb = exp_q.pop_front();
                    check("bit_high_len", hi_cnt, eb ? TH1 : TH0);
                end
            end
            if (frame_done) begin
                check("done_in_frame", frame_active, 1);
                check("frame_len", cyc - first_rise, FRAME);
                check("bits_left_at_done", exp_q.size(), 0);
                frame_active = 1'b0;
                in_bit       = 1'b0;
                done_cnt++;
            end
        end
        prev_dout = dout;
    end

    // Every read strobe must match the next expected address
    always @(negedge clk) begin
        if (cs) begin
            if (addr_q.size() == 0) check("unexpected_read", 1, 0);
            else check("read_addr", addr, addr_q.pop_front());
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic run_start(output int frise);
        int  s;
        bit  seen;
        for (int i = 0; i < N; i++) begin
            addr_q.push_back(i);
            for (int b = 23; b >= 0; b--) exp_q.push_back(mem[i][b]);
        end
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_cs", cs, 1);
        check("start_addr", addr, 0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (dout) seen = 1'b1;
            else @(negedge clk);
        end
        check("first_rise_seen", seen, 1);
        check("first_rise_latency", cyc - s, 3);
        frise = cyc;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_seen", seen, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        mon_abort = 1'b1;
        mem[0] = 32'h00FF0000;
        mem[1] = 32'h00AA55F0;
        mem[2] = 32'h00000001;

        // Reset with start held high
        repeat (4) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_cs", cs, 0);
        check("rst_addr", addr, 0);
        check("const_clken", clken, 1);
        check("const_write", wr, 0);
        check("const_wdata", wdata, 0);
        check("const_be", be, 4'hF);
        rst       = 1'b0;
        start     = 1'b0;
        mon_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        // Frame 1: start pulses mid-frame, in LATCH and on the done cycle are all ignored
        run_start(f1);
        wait_until(f1 + 5 * TBIT + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_at_bit5", busy, 1);
        wait_until(f1 + N * 24 * TBIT + 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_in_latch", busy, 1);
        check("dout_in_latch", dout, 0);
        wait_done(FRAME + 200);
        check("busy_on_done", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start_ignored", busy, 0);
        repeat (50) @(negedge clk);
        check("f1_idle_busy", busy, 0);
        check("f1_done_count", done_cnt, 1);
        check("f1_reads_left", addr_q.size(), 0);
        check("f1_bits_left", exp_q.size(), 0);

        // Frame 2: reset during the high phase of LED 1
        mem[0] = 32'h00AA55F0;
        mem[1] = 32'h00000001;
        mem[2] = 32'h00800000;
        run_start(f2);
        wait_until(f2 + 24 * TBIT + 5);
        check("pre_rst_high", dout, 1);
        mon_abort = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        check("post_rst_dout", dout, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", frame_done, 0);
        rst = 1'b0;
        repeat (FRAME) @(negedge clk);
        check("no_done_after_rst", done_cnt, 1);
        check("rst_idle_busy", busy, 0);
        check("f2_reads_left", addr_q.size(), 0);
        exp_q.delete();
        mon_abort = 1'b0;
        @(negedge clk);

        // Frame 3: restart reads from address 0 and completes normally
        run_start(f3);
        wait_done(FRAME + 200);
        @(negedge clk);
        check("f3_done_count", done_cnt, 2);
        repeat (10) @(negedge clk);
        check("f3_reads_left", addr_q.size(), 0);
        check("f3_bits_left", exp_q.size(), 0);
        check("f3_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_ram_ws2812_tx.md
# led_ram_ws2812_tx

Downstream consumer of the SoC's exported `led_ram` on-chip memory port. On a frame request it reads N_LEDS colour words from `led_ram`, prefetching one word ahead, and serialises each as 24 GRB bits on a single WS2812 data line with cycle-exact high/low timing. It then holds the line low for the latch period. It runs in the 40 MHz domain (`o_clock_40m_clk`) and drives the physical Ambilight strip.

## Interface
- `N_LEDS`, 120: LEDs per frame; 1..2048.
- `RD_LATENCY`, 1: `led_ram` read latency in cycles (1 or 2).
- `T0H`, 16: high cycles for a 0 bit (400 ns at 40 MHz).
- `T1H`, 32: high cycles for a 1 bit (800 ns).
- `T_BIT`, 50: total cycles per bit (1.25 µs).
- `T_RESET`, 2400: low cycles for latch (60 µs).
- `i_clk` in 1: the only clock; `o_clock_40m_clk`.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_start` in 1: frame request pulse; honoured only in IDLE.
- `o_busy` out 1: frame in progress.
- `o_frame_done` out 1: one-cycle pulse at end of latch.
- `o_led_ram_address` out 11: word address.
- `o_led_ram_chipselect` out 1: read strobe.
- `o_led_ram_clken` out 1: constant 1.
- `o_led_ram_write` out 1: constant 0.
- `o_led_ram_writedata` out 32: constant 0.
- `o_led_ram_byteenable` out 4: constant 4'hF.
- `i_led_ram_readdata` in 32: word; [23:16]=G, [15:8]=R, [7:0]=B, [31:24]=brightness (used only under macro).
- `o_led_dout` out 1: WS2812 data line.

## Operation
- Reset values:
  - `o_led_dout`, `o_busy`, `o_frame_done`, `o_led_ram_chipselect` = 0.
  - Address = 0.
  - FSM in IDLE.
- FSM states: IDLE → PRIME → SEND → LATCH → IDLE.
- IDLE:
  - Line low.
  - `i_start`=1 → PRIME; issue read of address 0.
- PRIME:
  - Wait RD_LATENCY cycles, then capture the word into the shift register → SEND.
  - Issue a prefetch read of address 1 when N_LEDS>1.
- SEND:
  - Per bit, MSB first (G7..B0):
    - Line high for T1H (bit=1) or T0H (bit=0) cycles.
    - Then low until T_BIT cycles elapse.
  - After bit 0 of LED k:
    - If k<N_LEDS-1, load the prefetch buffer into the shift register with zero gap (next bit starts on the following cycle).
    - Issue the read for LED k+2 if it exists.
    - If k=N_LEDS-1 → LATCH.
- Prefetch guarantee: data is always ready ≥T_BIT cycles before it is needed, so no gap between LEDs.
- LATCH:
  - Line low for T_RESET cycles.
  - Then `o_frame_done`=1 for one cycle, `o_busy`=0 the same cycle → IDLE.
- `i_start` outside IDLE is ignored (not queued). `i_start` in the cycle `o_frame_done` is asserted is ignored.
- `i_rst` mid-frame: the next cycle has line low, busy 0, no `o_frame_done` pulse.
- Address counter is 11-bit and never exceeds N_LEDS-1; no wrap.
- Bit counter is 5-bit (0..23); timing counter is sized for max(T_BIT, T_RESET).

## Timing
- Start cycle and read issue:
  - `i_start` sampled high in cycle S.
  - `o_busy`=1, address 0, chipselect=1 in S+1.
- Readdata for address 0 is valid in S+1+RD_LATENCY and captured at the end of that cycle.
- First rising edge of `o_led_dout` at S+2+RD_LATENCY; add 1 cycle under `LED_BRIGHTNESS_EN`.
- Frame length from first rise to `o_frame_done` = N_LEDS·24·T_BIT + T_RESET cycles.
- Chipselect is asserted exactly one cycle per read.

## Configuration
- `LED_BRIGHTNESS_EN`:
  - Defined: each captured channel c becomes (c·(br+1))>>8, with br = word[31:24]. This is a registered multiply stage; it adds 1 cycle to the PRIME latency and is absorbed into the prefetch for later LEDs.
  - Undefined: word[31:24] ignored; channels transmitted unmodified; no multiplier.

## Structure
- Package `ws2812_pkg`:
  - state enum {IDLE, PRIME, SEND, LATCH};
  - default timing constants at 40 MHz;
  - GRB field bit positions.
- Sub-module `ws2812_bit_encoder`:
  - Inputs: bit value and a one-cycle launch strobe.
  - Outputs: line level and a bit-done strobe, asserted in the last cycle of T_BIT.
  - Owns the timing counter.

## Test plan
- Reset with `i_start` held high → all outputs 0, no read issued.
- N_LEDS=1, word 0x00FF0000, `i_start` pulse:
  - 8 bits of 32 high / 18 low, then 16 bits of 16 high / 34 low.
  - Then 2400 low cycles and `o_frame_done` at 24·50+2400 = 3600 cycles after the first rise.
- N_LEDS=3, words 0x00AA55F0, 0x00000001, 0x00800000:
  - Bit stream matches MSB-first with no idle cycle between LEDs.
  - Addresses read 0,1,2 each exactly once.
- `i_start` pulsed at bit 5 of LED 0 and again in LATCH → no restart, a single `o_frame_done`.
- `i_rst` asserted during a high phase of LED 1 → `o_led_dout`=0 and `o_busy`=0 the next cycle; a later `i_start` re-reads from address 0.
- With `LED_BRIGHTNESS_EN` defined, word 0x7F808080 → transmitted GRB 0x40,0x40,0x40; first rise at S+4 for RD_LATENCY=1.
